// File: rtl/branch_offset_encoder_pkg.sv
// Shared constants for the branch offset encoder: default widths, PC increment,
// offset bounds and result-flag bit positions.
package branch_offset_encoder_pkg;

    localparam int unsigned PC_W_DEF  = 32;
    localparam int unsigned OFS_W_DEF = 11;
    localparam int unsigned PC_INC    = 4;

    localparam int OFS_MAX = (1 << (OFS_W_DEF - 1)) - 1;
    localparam int OFS_MIN = -(1 << (OFS_W_DEF - 1));

    // Result flags travel next to the offset through stage 2
    localparam int unsigned FLAG_W     = 2;
    localparam int unsigned FLAG_ALIGN = 0;
    localparam int unsigned FLAG_RANGE = 1;

endpackage

// File: rtl/branch_offset_encoder_pipe_stage_reg.sv
// Generic valid/ready register slice: holds one item, accepts a new one whenever
// it is empty or its current item leaves in the same cycle.
module pipe_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         load;

    assign in_ready  = !valid_q || out_ready;
    assign load      = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_offset_encoder.sv
// Encodes an absolute branch target into a signed word-offset field relative to PC+4.
// Optional saturating error counter on out_err_cnt when ERR_CNT_EN is defined.
module branch_offset_encoder
    import branch_offset_encoder_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned OFS_W = OFS_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [PC_W-1:0]  in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OFS_W-1:0] out_ofs,
    output logic             out_align_err,
    output logic             out_range_err
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]       out_err_cnt
`endif
);

    localparam int unsigned S1_W = PC_W + 2;
    localparam int unsigned S2_W = OFS_W + FLAG_W;

    localparam logic signed [PC_W:0] WOFS_MAX = (PC_W + 1)'((1 << (OFS_W - 1)) - 1);
    localparam logic signed [PC_W:0] WOFS_MIN = -WOFS_MAX - 1;

    logic [PC_W:0]        s1_in_diff;
    logic                 s1_in_align;
    logic                 s1_valid;
    logic [S1_W-1:0]      s1_data;
    logic                 s2_ready;
    logic signed [PC_W:0] s1_diff;
    logic                 s1_align;
    logic signed [PC_W:0] wofs;
    logic [FLAG_W-1:0]    s2_in_flags;
    logic [OFS_W-1:0]     s2_in_ofs;
    logic [S2_W-1:0]      s2_data;

    // One extra bit keeps targets behind a PC near the top of memory negative
    assign s1_in_diff  = {1'b0, in_target} - ({1'b0, in_pc} + (PC_W + 1)'(PC_INC));
    assign s1_in_align = (in_pc[1:0] != 2'b00) || (in_target[1:0] != 2'b00);

    pipe_stage_reg #(
        .W(S1_W)
    ) u_s1 (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({s1_in_diff, s1_in_align}),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_data)
    );

    assign s1_diff  = $signed(s1_data[S1_W-1:1]);
    assign s1_align = s1_data[0];
    assign wofs     = s1_diff >>> 2;

    always_comb begin
        s2_in_flags             = '0;
        s2_in_flags[FLAG_ALIGN] = s1_align;
        s2_in_flags[FLAG_RANGE] = (wofs > WOFS_MAX) || (wofs < WOFS_MIN);
        s2_in_ofs               = '0;
        if (s2_in_flags == '0) begin
            s2_in_ofs = wofs[OFS_W-1:0];
        end
    end

    pipe_stage_reg #(
        .W(S2_W)
    ) u_s2 (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  ({s2_in_ofs, s2_in_flags}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (s2_data)
    );

    assign out_ofs       = s2_data[S2_W-1:FLAG_W];
    assign out_align_err = s2_data[FLAG_ALIGN];
    assign out_range_err = s2_data[FLAG_RANGE];

`ifdef ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (out_valid && out_ready && (out_align_err || out_range_err)
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign out_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed bench for branch_offset_encoder; define ERR_CNT_EN to also cover the error counter.
module tb_branch_offset_encoder;

    logic        Clk;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_ofs;
    logic        out_align_err;
    logic        out_range_err;
`ifdef ERR_CNT_EN
    logic [7:0]  out_err_cnt;
`endif

    int checks;
    int errors;
    int exp_cnt;
    int ready_lows;

    branch_offset_encoder dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_target    (in_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ofs      (out_ofs),
        .out_align_err(out_align_err),
        .out_range_err(out_range_err)
`ifdef ERR_CNT_EN
        ,
        .out_err_cnt  (out_err_cnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef ERR_CNT_EN
        check(tag, 32'(out_err_cnt), 32'(exp_cnt));
`endif
    endtask

    // Single request through an otherwise empty pipeline with out_ready held high
    task automatic run_one(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [10:0] e_ofs, input logic e_al, input logic e_rg);
        in_pc     = pc;
        in_target = tgt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge Clk); #1;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_ofs"}, 32'(out_ofs), 32'(e_ofs));
        check({tag, "_al"}, 32'(out_align_err), 32'(e_al));
        check({tag, "_rg"}, 32'(out_range_err), 32'(e_rg));
        @(posedge Clk); #1;
        if ((e_al || e_rg) && exp_cnt < 255) exp_cnt++;
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
        check_cnt({tag, "_cnt"});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = 0;
        ready_lows = 0;
        Rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_target  = '0;
        out_ready  = 1'b0;
        #2;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_ofs", 32'(out_ofs), 32'd0);
        check("rst_al", 32'(out_align_err), 32'd0);
        check("rst_rg", 32'(out_range_err), 32'd0);
        check_cnt("rst_cnt");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);

        run_one("fwd3", 32'h100, 32'h110, 11'h003, 1'b0, 1'b0);
        run_one("back5", 32'h100, 32'h0F0, 11'h7FB, 1'b0, 1'b0);
        run_one("max", 32'h0, 32'h1000, 11'h3FF, 1'b0, 1'b0);
        run_one("max_p1", 32'h0, 32'h1004, 11'h000, 1'b0, 1'b1);
        run_one("align", 32'h102, 32'h110, 11'h000, 1'b1, 1'b0);
        run_one("min", 32'h1000, 32'h4, 11'h400, 1'b0, 1'b0);
        run_one("min_m1", 32'h1000, 32'h0, 11'h000, 1'b0, 1'b1);
        run_one("wrap", 32'hFFFF_FFFC, 32'h0, 11'h000, 1'b0, 1'b1);
        run_one("both", 32'h1, 32'h2000, 11'h000, 1'b1, 1'b1);
        run_one("top", 32'hFFFF_FFF0, 32'hFFFF_FFFC, 11'h002, 1'b0, 1'b0);

        // Backpressure: three back-to-back requests with the consumer stalled
        out_ready = 1'b0;
        in_pc     = 32'h100;
        in_target = 32'h110;
        in_valid  = 1'b1;
        @(posedge Clk); #1;
        check("bp_rdy1", 32'(in_ready), 32'd1);
        in_target = 32'h0F0;
        @(posedge Clk); #1;
        check("bp_vldA", 32'(out_valid), 32'd1);
        check("bp_ofsA", 32'(out_ofs), 32'h003);
        check("bp_full", 32'(in_ready), 32'd0);
        in_pc     = 32'h0;
        in_target = 32'h1000;
        @(posedge Clk); #1;
        check("bp_hold_vld", 32'(out_valid), 32'd1);
        check("bp_hold_ofs", 32'(out_ofs), 32'h003);
        check("bp_hold_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_pass", 32'(in_ready), 32'd1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("bp_vldB", 32'(out_valid), 32'd1);
        check("bp_ofsB", 32'(out_ofs), 32'h7FB);
        @(posedge Clk); #1;
        check("bp_vldC", 32'(out_valid), 32'd1);
        check("bp_ofsC", 32'(out_ofs), 32'h3FF);
        @(posedge Clk); #1;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming misaligned requests at full rate saturates the counter
        in_pc     = 32'h102;
        in_target = 32'h110;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!in_ready) ready_lows++;
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        check("stream_rdy_lows", 32'(ready_lows), 32'd0);
        check("stream_al", 32'(out_align_err), 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        exp_cnt = 255;
        check("stream_done", 32'(out_valid), 32'd0);
        check_cnt("sat_cnt");

        // Reset with both stages occupied
        out_ready = 1'b0;
        in_pc     = 32'h100;
        in_target = 32'h110;
        in_valid  = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_vld", 32'(out_valid), 32'd1);
        Rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        check("mid_rst_ofs", 32'(out_ofs), 32'd0);
        check_cnt("mid_rst_cnt");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("post_rst_stale", 32'(out_valid), 32'd0);
        run_one("post_rst", 32'h200, 32'h1F0, 11'h7FB, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
